// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader writing instruction memory and gating CPU reset
module prog_loader #(
    parameter int         WORDS = 256,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHK    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]  state;
    logic [15:0] count;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    logic        accept;
    logic [15:0] count_next;
    logic        count_bad;

    assign in_ready = (state == S_IDLE) || (state == S_CNT_LO) || (state == S_CNT_HI) ||
                      (state == S_DATA) || (state == S_CHK);
    assign accept     = in_valid & in_ready;
    assign mem_en     = (state == S_WRITE);
    assign mem_we     = (state == S_WRITE);
    assign count_next = {in_data, count[7:0]};
    assign count_bad  = (count_next == 16'd0) || (32'(count_next) > WORDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            words_loaded <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && in_data == SYNC)
                        state <= S_CNT_LO;
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count[7:0] <= in_data;
                        state      <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        if (count_bad) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            csum         <= '0;
                            byte_idx     <= '0;
                            words_loaded <= '0;
                            state        <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        shift    <= {in_data, shift[23:8]};
                        // Latch address/data on the last byte so they are stable through WRITE and hold afterwards
                        if (byte_idx == 2'd3) begin
                            mem_addr  <= {16'd0, words_loaded};
                            mem_wdata <= {in_data, shift[23:0]};
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                    state        <= (words_loaded + 16'd1 == count) ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state    <= S_IDLE;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader that writes instruction memory, the write side of the instruction fetch path. It accepts a framed byte stream (sync, word count, little-endian words, XOR checksum) over a valid/ready handshake. It writes each assembled 32-bit word into the instruction memory write port. It holds the CPU in reset until a complete, checksum-verified image has been written.

Parameters:
WORDS, 256, instruction memory depth in words; legal count is 1..WORDS
SYNC, 8'hA5, frame sync byte

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle
start  input  1  one-cycle pulse; in DONE/ERR re-arms the loader for a new frame
mem_en  output  1  imem enable (write cycle)
mem_we  output  1  imem write enable
mem_addr  output  32  imem word address (word index, zero-extended)
mem_wdata  output  32  imem write data
cpu_hold  output  1  drives CPU reset; 1 = CPU held
done  output  1  image loaded and verified
err  output  1  frame error (bad count or checksum)
words_loaded  output  16  words written in the current frame

Behaviour:
- Reset (async, rst=1) forces the following. State=IDLE. in_ready=1. mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. cpu_hold=1. done=0, err=0. words_loaded=0. The checksum accumulator and the byte index are cleared. Reset mid-frame discards the partial frame; words already written stay in memory.
- A byte transfers on a clk rising edge when in_valid & in_ready. in_data is ignored otherwise.
- States:
  - IDLE: in_ready=1. Accepted byte == SYNC goes to CNT_LO. Any other byte is discarded and the state stays IDLE.
  - CNT_LO: captures count[7:0] and goes to CNT_HI.
  - CNT_HI: captures count[15:8]. If the 16-bit count is 0 or > WORDS, go to ERR. Otherwise clear the checksum, byte index and words_loaded, then go to DATA.
  - DATA: in_ready=1. Bytes shift into the word little-endian (byte 0 -> bits 7:0). Each byte is XORed into the 8-bit checksum. The 4th accepted byte goes to WRITE.
  - WRITE: lasts exactly 1 cycle with in_ready=0, mem_en=1, mem_we=1, mem_addr=words_loaded, mem_wdata=the assembled word. words_loaded increments at the end of the cycle. Next state is CHK if words_loaded+1 == count, else DATA.
  - CHK: in_ready=1. If the accepted byte equals the checksum, go to DONE; otherwise go to ERR.
  - DONE: done=1, cpu_hold=0, in_ready=0.
  - ERR: err=1, cpu_hold=1, in_ready=0.
- cpu_hold is 1 in every state except DONE. It deasserts the cycle after the checksum byte is accepted.
- done and err are registered, mutually exclusive and sticky until start or rst.
- start:
  - Honoured only in DONE or ERR. It goes to IDLE, clears done/err, and reasserts cpu_hold on the next cycle.
  - Ignored in all other states.
- mem_en and mem_we are 0 outside WRITE. mem_addr and mem_wdata hold their last values outside WRITE.
- Write latency: the write pulse occurs on the cycle immediately after the 4th byte of a word is accepted. Minimum frame time is 3 + 5N + 1 cycles.
- Bubbles (in_valid=0) in any state stall without side effects.
- The checksum covers data bytes only, not the sync, count or checksum bytes.

Test Plan:
1. Good frame A5 02 00 44 33 22 11 EF BE AD DE 66, sent back-to-back.
   - Writes addr0=0x11223344 and addr1=0xDEADBEEF, one WRITE pulse each.
   - done=1 and cpu_hold=0 the cycle after byte 66; words_loaded=2.
2. Same frame with checksum 67 -> both words are still written; err=1, done=0, cpu_hold stays 1.
3. Count checks:
   - Frame A5 00 00 -> ERR immediately; no mem_we pulse.
   - Frame A5 01 01 (257 > WORDS) -> ERR.
4. Garbage 00 FF 5A before A5, plus in_valid gaps of 0-3 cycles between every byte of frame 1 -> result identical to scenario 1.
5. rst asserted after 6 data bytes of frame 1, then frame 1 resent in full:
   - During reset: outputs at reset values; addr0 already written.
   - After the resend: words_loaded=2, done=1.
6. start pulse in ERR (from scenario 2), then a new good frame A5 01 00 01 00 00 00 01:
   - err clears and cpu_hold stays 1 during the load.
   - Writes addr0=0x00000001, then done=1.
   - start pulsed in DATA is ignored.
